cgra_launch_ctrl: RTL and testbench

- Host-side launch sequencer directly upstream of the CGRA top level.
- Accepts a batch command from the software register bank and drives the level-style Computation_Start / Computation_Done handshake once per kernel invocation.
- Repeats the handshake for N back-to-back invocations, then reports completion, launch count and elapsed cycles to software.

---
 rtl/cgra_launch_ctrl_if.sv | 33 +++
 rtl/cgra_launch_ctrl.sv | 154 +++++++++++++++
 tb/tb_cgra_launch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_launch_ctrl_if.sv
// Command / status / CGRA handshake bundle for cgra_launch_ctrl.
// The controller is on the slave side; the software bank and CGRA model are on the master side.
interface cgra_launch_ctrl_if #(
  parameter int BATCH_WIDTH = 16,
  parameter int CNT_WIDTH   = 32
);
  // Cmd_Valid/Cmd_Ready: a command transfers on any rising edge where both are high;
  // Cmd_Batch must be stable while Cmd_Valid is high and is sampled on that edge only.
  logic                   Cmd_Valid;
  logic                   Cmd_Ready;
  logic [BATCH_WIDTH-1:0] Cmd_Batch;
  logic                   Cmd_Abort;
  logic                   Computation_Start;
  logic                   Computation_Done;
  logic                   Busy;
  logic                   Batch_Done;
  logic [BATCH_WIDTH-1:0] Launch_Count;
  logic [CNT_WIDTH-1:0]   Cycle_Count;
  logic [1:0]             Status;
  logic                   Irq;

  modport slave (
    input  Cmd_Valid, Cmd_Batch, Cmd_Abort, Computation_Done,
    output Cmd_Ready, Computation_Start, Busy, Batch_Done,
           Launch_Count, Cycle_Count, Status, Irq
  );

  modport master (
    output Cmd_Valid, Cmd_Batch, Cmd_Abort, Computation_Done,
    input  Cmd_Ready, Computation_Start, Busy, Batch_Done,
           Launch_Count, Cycle_Count, Status, Irq
  );
endinterface

// File: rtl/cgra_launch_ctrl.sv
// Batch launch sequencer: runs the CGRA Computation_Start/Done level handshake N times per command.
// Define CGRA_LAUNCH_WATCHDOG_EN to build the per-phase watchdog (Status 3 on expiry).
module cgra_launch_ctrl #(
  parameter int BATCH_WIDTH    = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              Clk,
  input  logic              Resetn,
  cgra_launch_ctrl_if.slave bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_ABORT  = 2'd1;
  localparam logic [1:0] ST_BADCMD = 2'd2;

  state_t                 r_state;
  state_t                 w_next;
  logic [BATCH_WIDTH-1:0] r_remaining;
  logic [BATCH_WIDTH-1:0] r_launch;
  logic [CNT_WIDTH-1:0]   r_cycles;
  logic [1:0]             r_status;
  logic                   r_irq;
  logic                   r_busy;
  logic                   r_start;
  logic                   r_abort_pend;
  logic                   w_abort;
  logic                   w_accept;
  logic                   w_fin_en;
  logic [1:0]             w_fin_code;
  logic                   w_launch_inc;

`ifdef CGRA_LAUNCH_WATCHDOG_EN
  localparam logic [1:0] ST_TIMEOUT = 2'd3;
  localparam int         WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_phase_cnt;
  logic            w_wd_expired;

  // Counter restarts whenever the state changes, so each ARM/ASSERT/RELEASE visit gets a full budget.
  always_ff @(posedge Clk) begin
    if (!Resetn || (w_next != r_state)) r_phase_cnt <= '0;
    else if (r_phase_cnt != {WD_W{1'b1}}) r_phase_cnt <= r_phase_cnt + 1'b1;
  end

  assign w_wd_expired = (r_state == S_ARM || r_state == S_ASSERT || r_state == S_RELEASE) &&
                        (r_phase_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  assign w_accept = (r_state == S_IDLE) && bus.Cmd_Valid;
  assign w_abort  = r_abort_pend | bus.Cmd_Abort;

  always_comb begin
    w_next       = r_state;
    w_fin_en     = 1'b0;
    w_fin_code   = ST_OK;
    w_launch_inc = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.Cmd_Valid) w_next = S_ARM;
      S_ARM: begin
        if (w_abort) begin
          w_next = S_FINISH; w_fin_en = 1'b1; w_fin_code = ST_ABORT;
        end else if (r_remaining == '0) begin
          w_next = S_FINISH; w_fin_en = 1'b1; w_fin_code = ST_BADCMD;
        end else if (!bus.Computation_Done) begin
          w_next = S_ASSERT;
        end
      end
      S_ASSERT:  if (bus.Computation_Done) w_next = S_RELEASE;
      S_RELEASE: begin
        // A kernel only counts once the CGRA has dropped Done again.
        if (!bus.Computation_Done) begin
          w_launch_inc = 1'b1;
          if (w_abort || r_remaining == BATCH_WIDTH'(1)) begin
            w_next     = S_FINISH;
            w_fin_en   = 1'b1;
            w_fin_code = w_abort ? ST_ABORT : ST_OK;
          end else begin
            w_next = S_ARM;
          end
        end
      end
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
`ifdef CGRA_LAUNCH_WATCHDOG_EN
    if (w_wd_expired && (w_next == r_state)) begin
      w_next       = S_FINISH;
      w_fin_en     = 1'b1;
      w_fin_code   = ST_TIMEOUT;
      w_launch_inc = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_launch     <= '0;
      r_cycles     <= '0;
      r_status     <= ST_OK;
      r_irq        <= 1'b0;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == S_ASSERT);
      if (w_accept) begin
        // The accept cycle itself is the first counted cycle; any abort seen here is dropped.
        r_remaining  <= bus.Cmd_Batch;
        r_launch     <= '0;
        r_cycles     <= CNT_WIDTH'(1);
        r_status     <= ST_OK;
        r_irq        <= 1'b0;
        r_busy       <= 1'b1;
        r_abort_pend <= 1'b0;
      end else begin
        if (r_busy && (r_cycles != {CNT_WIDTH{1'b1}})) r_cycles <= r_cycles + 1'b1;
        if ((r_state != S_IDLE) && bus.Cmd_Abort) r_abort_pend <= 1'b1;
        if (w_launch_inc) begin
          r_launch    <= r_launch + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_fin_en) r_status <= w_fin_code;
        if (r_state == S_FINISH) begin
          r_busy       <= 1'b0;
          r_irq        <= 1'b1;
          r_abort_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.Cmd_Ready         = (r_state == S_IDLE);
  assign bus.Computation_Start = r_start;
  assign bus.Busy              = r_busy;
  assign bus.Batch_Done        = (r_state == S_FINISH);
  assign bus.Launch_Count      = r_launch;
  assign bus.Cycle_Count       = r_cycles;
  assign bus.Status            = r_status;
  assign bus.Irq               = r_irq;
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// Bench for cgra_launch_ctrl: directed batches from the test plan plus randomized batches
// with a reactive CGRA model and a spec-level result model feeding an expected queue.
module tb_cgra_launch_ctrl;
  localparam int BW = 16;
  localparam int CW = 32;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [CW-1:0] exp_q[$];

  cgra_launch_ctrl_if #(.BATCH_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

  cgra_launch_ctrl #(.BATCH_WIDTH(BW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .Clk        (clk),
    .Resetn     (resetn),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result of a batch from the command-level rules: mode 0 plain, 1 abort alongside the
  // command (discarded), 2 abort right after accept, 3 abort while kernel k is running.
  function automatic void model(input int b, input int mode, input int k,
                                output int launches, output int st);
    if (b == 0)           begin launches = 0;               st = 2; end
    else if (mode == 2)   begin launches = 0;               st = 1; end
    else if (mode == 3)   begin launches = (k < b) ? k : b; st = 1; end
    else                  begin launches = b;               st = 0; end
  endfunction

  // ---------------- driver + CGRA model ----------------
  task automatic run_batch(input int b, input int mode, input int k, input int stale);
    int exp_l, exp_s, f, starts, gap, cg, cnt, dhi, dlo;
    logic [CW-1:0] q_launch, q_status;
    bit prev_start, gap_active;
    model(b, mode, k, exp_l, exp_s);
    exp_q.push_back(CW'(exp_l));
    exp_q.push_back(CW'(exp_s));
    check_eq("ready_idle", bus.Cmd_Ready, 1);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Batch = BW'(b);
    bus.Cmd_Abort = (mode == 1);
    step();
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Abort = 1'b0;
    check_eq("accept_busy", bus.Busy, 1);
    check_eq("accept_ready", bus.Cmd_Ready, 0);
    check_eq("accept_irq_clr", bus.Irq, 0);
    check_eq("accept_cycles", bus.Cycle_Count, 1);
    check_eq("accept_launch", bus.Launch_Count, 0);
    f = 0; starts = 0; gap = 0; gap_active = 0; prev_start = 0;
    cnt = 0; dhi = 0; dlo = 0;
    cg = (stale > 0) ? 5 : 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      bus.Cmd_Abort = (mode == 2 && cyc == 1);
      if (bus.Batch_Done) begin
        f = cyc;
        break;
      end
      if (bus.Computation_Start && !prev_start) begin
        starts++;
        check_eq("start_done_low", bus.Computation_Done, 0);
        if (gap_active) check_eq("start_gap", gap, 1);
        gap_active = 0;
      end else if (gap_active && !bus.Computation_Start) begin
        gap++;
      end
      prev_start = bus.Computation_Start;
      case (cg)
        5: begin
          check_eq("stale_hold", bus.Computation_Start, 0);
          if (cyc >= stale) begin bus.Computation_Done = 1'b0; cg = 0; end
        end
        0: if (bus.Computation_Start) begin
          cg = 1; cnt = 1; dhi = $urandom_range(3, 12);
        end
        1: begin
          cnt++;
          if (mode == 3 && starts == k && cnt == 2) bus.Cmd_Abort = 1'b1;
          if (cnt >= dhi) begin bus.Computation_Done = 1'b1; cg = 2; end
        end
        2: begin
          check_eq("start_fall", bus.Computation_Start, 0);
          cg = 3; cnt = 0; dlo = $urandom_range(1, 4);
        end
        3: begin
          cnt++;
          if (cnt >= dlo) begin
            bus.Computation_Done = 1'b0; cg = 0; gap_active = 1; gap = 0;
          end
        end
        default: cg = 0;
      endcase
      step();
    end
    bus.Cmd_Abort = 1'b0;
    q_launch = exp_q.pop_front();
    q_status = exp_q.pop_front();
    if (f == 0) begin
      check_eq("batch_timeout", 0, 1);
    end else begin
      if (b == 0 || mode == 2) check_eq("finish_latency", f, 2);
      check_eq("start_pulses", starts, exp_l);
      step();
      check_eq("done_pulse_len", bus.Batch_Done, 0);
      check_eq("end_ready", bus.Cmd_Ready, 1);
      check_eq("end_busy", bus.Busy, 0);
      check_eq("end_irq", bus.Irq, 1);
      check_eq("end_start", bus.Computation_Start, 0);
      check_eq("launch_count", bus.Launch_Count, q_launch);
      check_eq("status", bus.Status, q_status);
      check_eq("cycle_count", bus.Cycle_Count, f + 1);
      repeat (3) step();
      check_eq("hold_launch", bus.Launch_Count, q_launch);
      check_eq("hold_cycles", bus.Cycle_Count, f + 1);
      check_eq("hold_irq", bus.Irq, 1);
    end
  endtask

  task automatic mid_reset();
    bit seen;
    seen = 0;
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Batch = BW'(3);
    step();
    bus.Cmd_Valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.Computation_Start) seen = 1;
      else step();
    end
    check_eq("rst_start_seen", seen, 1);
    resetn = 1'b0;
    bus.Computation_Done = 1'b1;
    step();
    check_eq("rst_start", bus.Computation_Start, 0);
    check_eq("rst_ready", bus.Cmd_Ready, 1);
    check_eq("rst_launch", bus.Launch_Count, 0);
    check_eq("rst_cycles", bus.Cycle_Count, 0);
    check_eq("rst_busy", bus.Busy, 0);
    check_eq("rst_irq", bus.Irq, 0);
    resetn = 1'b1;
  endtask

`ifdef CGRA_LAUNCH_WATCHDOG_EN
  task automatic watchdog_run();
    int hi, f;
    hi = 0; f = 0;
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Batch = BW'(1);
    step();
    bus.Cmd_Valid = 1'b0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      if (bus.Batch_Done) begin f = cyc; break; end
      if (bus.Computation_Start) hi++;
      step();
    end
    check_eq("wd_finished", (f > 0), 1);
    check_eq("wd_assert_len", hi, TO);
    check_eq("wd_start_low", bus.Computation_Start, 0);
    step();
    check_eq("wd_status", bus.Status, 3);
    check_eq("wd_launch", bus.Launch_Count, 0);
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    int b, m, k, r;
    resetn = 1'b0;
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Batch = '0;
    bus.Cmd_Abort = 1'b0;
    bus.Computation_Done = 1'b0;
    repeat (3) step();
    check_eq("reset_ready", bus.Cmd_Ready, 1);
    check_eq("reset_start", bus.Computation_Start, 0);
    check_eq("reset_busy", bus.Busy, 0);
    check_eq("reset_done", bus.Batch_Done, 0);
    check_eq("reset_launch", bus.Launch_Count, 0);
    check_eq("reset_cycles", bus.Cycle_Count, 0);
    check_eq("reset_status", bus.Status, 0);
    check_eq("reset_irq", bus.Irq, 0);
    resetn = 1'b1;
    step();
    bus.Cmd_Abort = 1'b1;
    step();
    bus.Cmd_Abort = 1'b0;
    run_batch(1, 0, 0, 0);
    run_batch(3, 0, 0, 0);
    run_batch(0, 0, 0, 0);
    run_batch(5, 3, 2, 0);
    run_batch(3, 1, 0, 0);
    run_batch(4, 2, 0, 0);
    mid_reset();
    run_batch(2, 0, 0, 6);
    for (int i = 0; i < 12; i++) begin
      b = $urandom_range(1, 4);
      r = $urandom_range(0, 2);
      m = (r == 2) ? 3 : r;
      k = $urandom_range(1, b);
      run_batch(b, m, k, 0);
    end
`ifdef CGRA_LAUNCH_WATCHDOG_EN
    watchdog_run();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
